icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache.
- Acts as the responder on the fetch-stage Icache interface: fetch drives ADR_SI/ADR_VALID_SI; the cache returns IC_INST_SI or holds IC_STALL_SI high.
- On a miss it refills one full line from the memory bus using a single-outstanding request/ack handshake.
- Storage is flop-based, so lookup is combinational; hits return data in the same cycle.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2, >=2).
- NB_LINES, 64, number of lines (power of 2).
- NOP_INSTR, 32'h00000013, value driven on IC_INST_SI when the data is not valid.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ADR_SI  in  32  fetch address (byte address, word aligned).
- ADR_VALID_SI  in  1  fetch request valid.
- IC_INST_SI  out  32  instruction at ADR_SI.
- IC_STALL_SI  out  1  request not served this cycle.
- IC_FLUSH_SI  in  1  invalidate all lines (fence.i); single-cycle pulse.
- MEM_ADR_SC  out  32  memory word read address.
- MEM_READ_SC  out  1  memory read request.
- MEM_DATA_SM  in  32  memory read data, valid with ack.
- MEM_ACK_SM  in  1  memory ack for the current request.

Behaviour:
- Address split:
  - bits [1:0] are ignored.
  - word offset: next log2(LINE_WORDS) bits.
  - index: next log2(NB_LINES) bits.
  - tag: remaining upper bits.
- Reset (async):
  - state=IDLE; all valid bits 0; word counter 0; flush_pending 0.
  - MEM_READ_SC=0, MEM_ADR_SC=0.
  - Tag and data arrays are not reset.
- hit = (state==IDLE) && valid[index] && tag[index]==tag(ADR_SI).
- IC_STALL_SI = ADR_VALID_SI && !hit (combinational).
- IC_INST_SI = data[index][offset] when hit, else NOP_INSTR.
- IDLE:
  - ADR_VALID_SI && !hit && !IC_FLUSH_SI: latch line base (ADR_SI with offset and byte bits zeroed) and index/tag; counter=0; go to REFILL.
  - IC_FLUSH_SI: clear all valid bits on the next edge. Flush wins over a same-cycle miss: the miss is not started, and the request re-looks up next cycle and misses.
- REFILL:
  - Drive MEM_READ_SC=1 and MEM_ADR_SC = base + 4*counter, held stable until MEM_ACK_SM.
  - On ack: write MEM_DATA_SM into data[idx][counter] and increment the counter.
  - Ack on the last word (counter==LINE_WORDS-1): write the tag, set valid (unless flush_pending), deassert MEM_READ_SC in the next cycle, go to DONE.
  - MEM_READ_SC may stay high across consecutive words; one ack per word, no more than one outstanding request.
  - Ack latency is arbitrary (0 wait allowed: ack in the same cycle as the request's first cycle).
- DONE:
  - One cycle with stall still asserted, then IDLE.
  - flush_pending is cleared here, and all valid bits are cleared if it was set.
- Refill is never aborted:
  - ADR_VALID_SI dropping or ADR_SI changing mid-refill does not abort it; the line completes.
  - On return to IDLE the current ADR_SI is looked up fresh (it may miss again).
- IC_FLUSH_SI during REFILL or DONE sets flush_pending. The refilled line is written but left invalid, and all valids are cleared.
- Miss-to-hit latency: with ack latency L cycles per word, the stall lasts 1 + LINE_WORDS*(L+1) + 1 cycles. This is the minimum for L=0.
- Reset asserted mid-refill aborts immediately: MEM_READ_SC=0 asynchronously; partial data is discarded because valid is 0.

Test Plan:
1. Cold miss, ADR_SI=0x00000100, ack latency 0:
   - Reads issued to 0x100, 0x104, 0x108, 0x10C in order; stall high throughout.
   - Then IC_INST_SI equals the word memory returned for 0x100, with stall 0.
2. After scenario 1, ADR_SI=0x0000010C:
   - Same-cycle hit, no MEM_READ_SC.
   - ADR_SI=0x00000110 misses, and the refill base is 0x110.
3. Conflict eviction:
   - Fill 0x100, then access 0x500 (same index with defaults): refill from 0x500.
   - Re-access 0x100: misses again.
4. Variable ack latency of 3 cycles:
   - MEM_ADR_SC is stable while waiting.
   - Exactly 4 acks are consumed; total stall is 1+4*4+1=18 cycles.
5. IC_FLUSH_SI pulsed during the 2nd word of a refill of 0x200:
   - Refill completes.
   - Subsequent 0x200 and the earlier cached 0x100 both miss.
6. reset_n low during the 3rd word of a refill:
   - MEM_READ_SC drops immediately.
   - After release, the same address misses and refill restarts at word 0.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-side port bundle of the direct-mapped instruction cache.
// The fetch stage is the master; the cache is the slave and returns data or stall.
interface icache_dm_if;
  logic [31:0] ADR_SI;
  logic        ADR_VALID_SI;
  logic [31:0] IC_INST_SI;
  logic        IC_STALL_SI;
  logic        IC_FLUSH_SI;

  modport master (
    output ADR_SI,
    output ADR_VALID_SI,
    output IC_FLUSH_SI,
    input  IC_INST_SI,
    input  IC_STALL_SI
  );

  modport slave (
    input  ADR_SI,
    input  ADR_VALID_SI,
    input  IC_FLUSH_SI,
    output IC_INST_SI,
    output IC_STALL_SI
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with flop storage: same-cycle hits and
// whole-line refill over a single-outstanding request/ack memory bus.
module icache_dm #(
  parameter int          LINE_WORDS = 4,
  parameter int          NB_LINES   = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  icache_dm_if.slave  fif,
  output logic [31:0] MEM_ADR_SC,
  output logic        MEM_READ_SC,
  input  logic [31:0] MEM_DATA_SM,
  input  logic        MEM_ACK_SM
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NB_LINES);
  localparam int BASE_W = 30 - OFF_W;
  localparam int TAG_W  = BASE_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_r;
  logic [NB_LINES-1:0] valid_r;
  logic [OFF_W-1:0]    cnt_r;
  logic                flush_pending_r;
  logic [BASE_W-1:0]   base_r;
  logic                mem_read_r;
  logic [31:0]         mem_adr_r;

  logic [TAG_W-1:0]    tag_mem_r  [NB_LINES];
  logic [31:0]         data_mem_r [NB_LINES][LINE_WORDS];

  logic [TAG_W-1:0]    req_tag_s;
  logic [IDX_W-1:0]    req_idx_s;
  logic [OFF_W-1:0]    req_off_s;
  logic [IDX_W-1:0]    fill_idx_s;
  logic [TAG_W-1:0]    fill_tag_s;
  logic [OFF_W-1:0]    cnt_inc_s;
  logic                last_s;
  logic                ack_s;
  logic                hit_s;
  logic [31:0]         inst_s;
  logic                unused_s;

  assign req_tag_s  = fif.ADR_SI[31 -: TAG_W];
  assign req_idx_s  = fif.ADR_SI[OFF_W+2 +: IDX_W];
  assign req_off_s  = fif.ADR_SI[2 +: OFF_W];
  assign fill_idx_s = base_r[IDX_W-1:0];
  assign fill_tag_s = base_r[BASE_W-1:IDX_W];
  assign cnt_inc_s  = cnt_r + {{(OFF_W-1){1'b0}}, 1'b1};
  assign last_s     = (cnt_r == {OFF_W{1'b1}});
  assign ack_s      = (state_r == REFILL) && MEM_ACK_SM;
  assign unused_s   = ^fif.ADR_SI[1:0];

  // Combinational lookup: only IDLE may hit, so refill and DONE cycles always stall.
  always_comb begin
    hit_s  = 1'b0;
    inst_s = NOP_INSTR;
    if ((state_r == IDLE) && valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s)) begin
      hit_s  = 1'b1;
      inst_s = data_mem_r[req_idx_s][req_off_s];
    end else begin
      hit_s  = 1'b0;
      inst_s = NOP_INSTR;
    end
  end

  assign fif.IC_INST_SI  = inst_s;
  assign fif.IC_STALL_SI = fif.ADR_VALID_SI && !hit_s;
  assign MEM_READ_SC     = mem_read_r;
  assign MEM_ADR_SC      = mem_adr_r;

  // Refill controller, valid bits and registered memory request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      valid_r         <= '0;
      cnt_r           <= '0;
      flush_pending_r <= 1'b0;
      base_r          <= '0;
      mem_read_r      <= 1'b0;
      mem_adr_r       <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          // A same-cycle flush beats the miss; the request simply misses again next cycle.
          if (fif.IC_FLUSH_SI) begin
            valid_r <= '0;
          end else if (fif.ADR_VALID_SI && !hit_s) begin
            base_r     <= fif.ADR_SI[31:OFF_W+2];
            cnt_r      <= '0;
            mem_read_r <= 1'b1;
            mem_adr_r  <= {fif.ADR_SI[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            state_r    <= REFILL;
          end
        end
        REFILL: begin
          if (fif.IC_FLUSH_SI) begin
            flush_pending_r <= 1'b1;
          end
          if (MEM_ACK_SM) begin
            cnt_r <= cnt_inc_s;
            if (last_s) begin
              mem_read_r <= 1'b0;
              if (!(flush_pending_r || fif.IC_FLUSH_SI)) begin
                valid_r[fill_idx_s] <= 1'b1;
              end
              state_r <= DONE;
            end else begin
              mem_adr_r <= {base_r, cnt_inc_s, 2'b00};
            end
          end
        end
        DONE: begin
          if (flush_pending_r || fif.IC_FLUSH_SI) begin
            valid_r <= '0;
          end
          flush_pending_r <= 1'b0;
          state_r         <= IDLE;
        end
        default: begin
          mem_read_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage: written only by refill acks, never reset.
  always_ff @(posedge clk) begin
    if (ack_s) begin
      data_mem_r[fill_idx_s][cnt_r] <= MEM_DATA_SM;
      if (last_s) begin
        tag_mem_r[fill_idx_s] <= fill_tag_s;
      end
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: stimulus queues expected memory reads and fetch
// results; a negedge monitor pops and compares whatever the cache presents.
module tb_icache_dm;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] inst;
    int          stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] MEM_ADR_SC;
  logic        MEM_READ_SC;
  logic [31:0] MEM_DATA_SM = 32'h0000_0000;
  logic        MEM_ACK_SM = 1'b0;

  icache_dm_if fif ();

  icache_dm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fif         (fif),
    .MEM_ADR_SC  (MEM_ADR_SC),
    .MEM_READ_SC (MEM_READ_SC),
    .MEM_DATA_SM (MEM_DATA_SM),
    .MEM_ACK_SM  (MEM_ACK_SM)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          lat = 0;
  int          wcnt = 0;
  logic [31:0] mem_q[$];
  exp_t        inst_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: word at address A reads as {C0DE, A[15:0]}; ack after lat wait cycles.
  always @(posedge clk) begin
    #2;
    if (MEM_READ_SC && reset_n) begin
      if (wcnt == lat) begin
        MEM_ACK_SM  = 1'b1;
        MEM_DATA_SM = {16'hC0DE, MEM_ADR_SC[15:0]};
        wcnt        = 0;
      end else begin
        MEM_ACK_SM = 1'b0;
        wcnt++;
      end
    end else begin
      MEM_ACK_SM = 1'b0;
      wcnt       = 0;
    end
  end

  int          run = 0;
  logic        prev_read = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_adr = 32'h0000_0000;
  logic [31:0] e_adr;
  exp_t        e_inst;

  // Monitor: memory handshakes, address stability, and served fetches.
  always @(negedge clk) begin
    if (!reset_n) begin
      run       = 0;
      prev_read = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (MEM_READ_SC && MEM_ACK_SM) begin
        if (mem_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_mem_read: got %h, expected no read", MEM_ADR_SC);
        end else begin
          e_adr = mem_q.pop_front();
          chk("mem_adr", MEM_ADR_SC, e_adr);
        end
      end
      if (MEM_READ_SC && prev_read && !prev_ack) chk("mem_adr_stable", MEM_ADR_SC, prev_adr);
      if (fif.ADR_VALID_SI) begin
        if (fif.IC_STALL_SI) begin
          run++;
          chk("nop_on_stall", fif.IC_INST_SI, NOP);
        end else if (inst_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_hit: got %h, expected stall", fif.IC_INST_SI);
        end else begin
          e_inst = inst_q.pop_front();
          chk("inst", fif.IC_INST_SI, e_inst.inst);
          chk("stall_cycles", 32'(run), 32'(e_inst.stall));
          run = 0;
        end
      end
      prev_read = MEM_READ_SC;
      prev_ack  = MEM_ACK_SM;
      prev_adr  = MEM_ADR_SC;
    end
  end

  task automatic push_line(input logic [31:0] base);
    for (int w = 0; w < 4; w++) mem_q.push_back(base + 32'(4 * w));
  endtask

  task automatic expect_hit(input logic [31:0] inst, input int stall);
    exp_t x;
    x.inst  = inst;
    x.stall = stall;
    inst_q.push_back(x);
  endtask

  task automatic drive(input logic [31:0] a);
    @(posedge clk);
    #1;
    fif.ADR_SI       = a;
    fif.ADR_VALID_SI = 1'b1;
  endtask

  task automatic wait_hit(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (fif.ADR_VALID_SI && !fif.IC_STALL_SI) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no hit, expected hit within 200 cycles", name);
    end
  endtask

  initial begin
    fif.ADR_SI       = 32'h0000_0000;
    fif.ADR_VALID_SI = 1'b0;
    fif.IC_FLUSH_SI  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", {31'd0, MEM_READ_SC}, 32'd0);
    chk("rst_mem_adr", MEM_ADR_SC, 32'h0000_0000);
    chk("rst_stall", {31'd0, fif.IC_STALL_SI}, 32'd0);
    chk("rst_inst", fif.IC_INST_SI, NOP);
    reset_n = 1'b1;

    // 1: cold miss, zero-wait memory
    push_line(32'h0000_0100);
    expect_hit(32'hC0DE_0100, 6);
    drive(32'h0000_0100);
    wait_hit("cold_miss");

    // 2: same-line hit, then next line misses
    expect_hit(32'hC0DE_010C, 0);
    drive(32'h0000_010C);
    wait_hit("same_line_hit");
    push_line(32'h0000_0110);
    expect_hit(32'hC0DE_0110, 6);
    drive(32'h0000_0110);
    wait_hit("next_line");

    // 3: conflict eviction on the shared index
    push_line(32'h0000_0500);
    expect_hit(32'hC0DE_0500, 6);
    drive(32'h0000_0500);
    wait_hit("evict");
    push_line(32'h0000_0100);
    expect_hit(32'hC0DE_0100, 6);
    drive(32'h0000_0100);
    wait_hit("re_miss");

    // 4: three wait cycles per word
    lat = 3;
    push_line(32'h0000_0300);
    expect_hit(32'hC0DE_0304, 18);
    drive(32'h0000_0304);
    wait_hit("slow_mem");
    lat = 0;

    // 5: flush during the second refill word; line refetched after DONE
    push_line(32'h0000_0200);
    push_line(32'h0000_0200);
    expect_hit(32'hC0DE_0200, 12);
    drive(32'h0000_0200);
    @(posedge clk);
    @(posedge clk);
    #1 fif.IC_FLUSH_SI = 1'b1;
    @(posedge clk);
    #1 fif.IC_FLUSH_SI = 1'b0;
    wait_hit("flush_refill");
    push_line(32'h0000_0100);
    expect_hit(32'hC0DE_0100, 6);
    drive(32'h0000_0100);
    wait_hit("flush_old_line");

    // 6: reset during the third refill word
    mem_q.push_back(32'h0000_0400);
    mem_q.push_back(32'h0000_0404);
    drive(32'h0000_0400);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("reset_read_drop", {31'd0, MEM_READ_SC}, 32'd0);
    chk("reset_adr_zero", MEM_ADR_SC, 32'h0000_0000);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    push_line(32'h0000_0400);
    expect_hit(32'hC0DE_0400, 6);
    wait_hit("post_reset");

    @(posedge clk);
    #1 fif.ADR_VALID_SI = 1'b0;
    repeat (2) @(negedge clk);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    chk("inst_q_drained", 32'(inst_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
